// File: rtl/alu_op_dispatcher_if.sv
// Command, ALU-request and response channels of alu_op_dispatcher bundled as one interface.
// err_timeout exists only when ALU_DISPATCH_TIMEOUT_EN is defined.
interface alu_op_dispatcher_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [7:0]       cmd_op;
    logic [31:0]      operand_a;
    logic [31:0]      operand_b;
    logic [7:0]       operator;
    logic             op_valid;
    logic             operation_done;
    logic [31:0]      result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             err_stray_done;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    logic             err_timeout;
`endif

    // Dispatcher side
    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, operation_done, result, rsp_ready,
        output cmd_ready, operand_a, operand_b, operator, op_valid,
               rsp_valid, rsp_result, rsp_tag, err_stray_done
`ifdef ALU_DISPATCH_TIMEOUT_EN
        , output err_timeout
`endif
    );

    // Producer / ALU / consumer side
    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, operation_done, result, rsp_ready,
        input  cmd_ready, operand_a, operand_b, operator, op_valid,
               rsp_valid, rsp_result, rsp_tag, err_stray_done
`ifdef ALU_DISPATCH_TIMEOUT_EN
        , input err_timeout
`endif
    );
endinterface

// File: rtl/alu_op_dispatcher.sv
// Buffers tagged ALU commands in a FIFO and issues them one at a time to alu_top.
// Define ALU_DISPATCH_TIMEOUT_EN to add a BUSY watchdog (TIMEOUT parameter, err_timeout port).
module alu_op_dispatcher #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
`ifdef ALU_DISPATCH_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_op_dispatcher_if.master  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    state_e           state_q, state_d;
    logic [31:0]      memA_q   [DEPTH];
    logic [31:0]      memB_q   [DEPTH];
    logic [7:0]       memOp_q  [DEPTH];
    logic [TAG_W-1:0] memTag_q [DEPTH];
    logic [PW:0]      wrPtr_q, rdPtr_q;
    logic [TAG_W-1:0] tagCnt_q;
    logic [31:0]      opA_q, opB_q;
    logic [7:0]       opCode_q;
    logic [TAG_W-1:0] curTag_q;
    logic [31:0]      rspResult_q;
    logic [TAG_W-1:0] rspTag_q;
    logic             strayErr_q;

    logic [PW-1:0]    wrIdx, rdIdx;
    logic             fifoFull, fifoEmpty;
    logic             push, pop, capture;
    logic [31:0]      captureData;

    assign wrIdx     = wrPtr_q[PW-1:0];
    assign rdIdx     = rdPtr_q[PW-1:0];
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrIdx == rdIdx);
    assign push      = bus.cmd_valid && !fifoFull;

    always_ff @(posedge clock) begin
        if (push) begin
            memA_q[wrIdx]   <= bus.cmd_a;
            memB_q[wrIdx]   <= bus.cmd_b;
            memOp_q[wrIdx]  <= bus.cmd_op;
            memTag_q[wrIdx] <= tagCnt_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            tagCnt_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q  <= wrPtr_q + 1'b1;
                tagCnt_q <= tagCnt_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q;
    logic          timeoutPulse_q;
    logic          timeoutFire;

    // Timer is zero in the first BUSY cycle, so it fires after exactly TIMEOUT BUSY cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q        <= '0;
            timeoutPulse_q <= 1'b0;
        end else begin
            timeoutPulse_q <= timeoutFire;
            if (state_q == BUSY) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end
        end
    end

    assign bus.err_timeout = timeoutPulse_q;
`endif

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        captureData = bus.result;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        timeoutFire = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.operation_done) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
`ifdef ALU_DISPATCH_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    capture     = 1'b1;
                    captureData = 32'hDEADBEEF;
                    timeoutFire = 1'b1;
                    state_d     = HOLD;
                end
`endif
            end
            HOLD: begin
                // A queued command issues on the same edge the response is taken.
                if (bus.rsp_ready) begin
                    if (!fifoEmpty) begin
                        pop     = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            opCode_q    <= '0;
            curTag_q    <= '0;
            rspResult_q <= '0;
            rspTag_q    <= '0;
            strayErr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                opA_q    <= memA_q[rdIdx];
                opB_q    <= memB_q[rdIdx];
                opCode_q <= memOp_q[rdIdx];
                curTag_q <= memTag_q[rdIdx];
            end
            if (capture) begin
                rspResult_q <= captureData;
                rspTag_q    <= curTag_q;
            end
            if (bus.operation_done && (state_q != BUSY)) begin
                strayErr_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready      = !fifoFull;
    assign bus.operand_a      = opA_q;
    assign bus.operand_b      = opB_q;
    assign bus.operator       = opCode_q;
    assign bus.op_valid       = (state_q == BUSY);
    assign bus.rsp_valid      = (state_q == HOLD);
    assign bus.rsp_result     = rspResult_q;
    assign bus.rsp_tag        = rspTag_q;
    assign bus.err_stray_done = strayErr_q;
endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Randomised bench for alu_op_dispatcher checked against a transaction-level queue model.
// Define ALU_DISPATCH_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=8.
module tb_alu_op_dispatcher;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        int          tag;
    } cmd_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    alu_op_dispatcher_if #(.TAG_W(TAG_W)) bus ();

    alu_op_dispatcher #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
`ifdef ALU_DISPATCH_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    cmd_t        cmdQ[$];
    cmd_t        inflight;
    int          fifoCnt;
    int          modelTag;
    bit          modelStray;
    bit          haveExp;
    logic [31:0] expResult;
    int          expTag;
    int          busyCnt;
    bit          stubEnable = 1'b1;
    int          stubDelay;
    int          dlyLo = 0;
    int          dlyHi = 3;
    bit          strayNow;
    int          accepted;
    int          sent;
    int          rspCount;
    bit          reached;
    bit          cv;

    function automatic logic [31:0] aluModel(input cmd_t c);
        case (c.op[1:0])
            2'd0:    return c.a ^ c.b;
            2'd1:    return c.a + c.b;
            2'd2:    return c.a - c.b;
            default: return c.a & c.b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock: snapshot handshake state, let the edge happen, then compare against the model.
    task automatic stepCycle();
        bit   sOpV, sRspV, sCmdR, sCmdV, sDone, sRspR;
        bit   expOp, expRsp, tmo, issue;
        int   sCnt;
        cmd_t sCmd;
        sOpV   = bus.op_valid;
        sRspV  = bus.rsp_valid;
        sCmdR  = bus.cmd_ready;
        sCmdV  = bus.cmd_valid;
        sDone  = bus.operation_done;
        sRspR  = bus.rsp_ready;
        sCnt   = fifoCnt;
        sCmd.a = bus.cmd_a;
        sCmd.b = bus.cmd_b;
        sCmd.op = bus.cmd_op;
        sCmd.tag = 0;
        @(posedge clock);
        @(negedge clock);
        tmo = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        if (sOpV && !sDone) begin
            busyCnt++;
            tmo = (busyCnt == TIMEOUT);
        end
`endif
        if (sOpV)       expOp = !(sDone || tmo);
        else if (sRspV) expOp = sRspR && (sCnt > 0);
        else            expOp = (sCnt > 0);
        expRsp = (sOpV && (sDone || tmo)) || (sRspV && !sRspR);

        if (sCmdV && sCmdR) begin
            sCmd.tag = modelTag;
            cmdQ.push_back(sCmd);
            modelTag = (modelTag + 1) % (1 << TAG_W);
            fifoCnt++;
        end
        if (sRspV && sRspR) haveExp = 1'b0;
        if (sOpV && sDone) begin
            haveExp   = 1'b1;
            expResult = aluModel(inflight);
            expTag    = inflight.tag;
        end else if (tmo) begin
            haveExp   = 1'b1;
            expResult = 32'hDEADBEEF;
            expTag    = inflight.tag;
        end
        if (sDone && !sOpV) modelStray = 1'b1;
        issue = expOp && !sOpV && (cmdQ.size() > 0);
        if (issue) begin
            inflight  = cmdQ.pop_front();
            fifoCnt--;
            busyCnt   = 0;
            stubDelay = $urandom_range(dlyHi, dlyLo);
        end

        checkOutput("op_valid", bus.op_valid, expOp);
        checkOutput("rsp_valid", bus.rsp_valid, expRsp);
        checkOutput("cmd_ready", bus.cmd_ready, fifoCnt < DEPTH);
        checkOutput("err_stray_done", bus.err_stray_done, modelStray);
`ifdef ALU_DISPATCH_TIMEOUT_EN
        checkOutput("err_timeout", bus.err_timeout, tmo);
`endif
        if (bus.op_valid && expOp) begin
            checkOutput("operand_a", bus.operand_a, inflight.a);
            checkOutput("operand_b", bus.operand_b, inflight.b);
            checkOutput("operator", bus.operator, inflight.op);
        end
        if (bus.rsp_valid && haveExp) begin
            checkOutput("rsp_result", bus.rsp_result, expResult);
            checkOutput("rsp_tag", bus.rsp_tag, expTag);
        end

        // ALU stub: completes the in-flight op after stubDelay cycles with garbage otherwise.
        bus.operation_done = 1'b0;
        bus.result         = $urandom;
        if (strayNow && !bus.op_valid) begin
            bus.operation_done = 1'b1;
            strayNow           = 1'b0;
        end else if (bus.op_valid && stubEnable) begin
            if (stubDelay == 0) begin
                bus.operation_done = 1'b1;
                bus.result         = aluModel(inflight);
            end else begin
                stubDelay--;
            end
        end
    endtask

    task automatic applyStimulus(input bit cmdValid, input bit rspReady,
                                 input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        bus.cmd_valid = cmdValid;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.rsp_ready = rspReady;
        stepCycle();
    endtask

    task automatic applyRandom(input bit cmdValid, input bit rspReady);
        applyStimulus(cmdValid, rspReady, $urandom, $urandom, 8'($urandom));
    endtask

    task automatic applyReset();
        bus.cmd_valid      = 1'b0;
        bus.cmd_a          = '0;
        bus.cmd_b          = '0;
        bus.cmd_op         = '0;
        bus.rsp_ready      = 1'b0;
        bus.operation_done = 1'b0;
        bus.result         = '0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_op_valid", bus.op_valid, 0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        checkOutput("rst_err_stray", bus.err_stray_done, 0);
        checkOutput("rst_rsp_result", bus.rsp_result, 0);
        checkOutput("rst_operand_a", bus.operand_a, 0);
`ifdef ALU_DISPATCH_TIMEOUT_EN
        checkOutput("rst_err_timeout", bus.err_timeout, 0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cmdQ.delete();
        fifoCnt    = 0;
        modelTag   = 0;
        modelStray = 1'b0;
        haveExp    = 1'b0;
        busyCnt    = 0;
        stubDelay  = 0;
        strayNow   = 1'b0;
    endtask

    task automatic waitRsp(input string name, input int budget);
        reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            if (bus.rsp_valid) reached = 1'b1;
            else applyRandom(1'b0, 1'b0);
        end
        checkOutput(name, reached, 1);
    endtask

    task automatic drain(input string name, input int budget);
        reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            if (!bus.op_valid && !bus.rsp_valid && fifoCnt == 0) reached = 1'b1;
            else applyRandom(1'b0, 1'b1);
        end
        checkOutput(name, reached, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset();

        // Single op with a fixed three-cycle ALU latency
        dlyLo = 2;
        dlyHi = 2;
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd7, 8'h01);
        waitRsp("t1_rsp_seen", 20);
        checkOutput("t1_result", bus.rsp_result, 32'd12);
        checkOutput("t1_tag", bus.rsp_tag, 0);
        checkOutput("t1_op_low", bus.op_valid, 0);
        applyRandom(1'b0, 1'b1);

        // Burst fill under back-pressure
        dlyLo = 0;
        dlyHi = 3;
        accepted = 0;
        for (int i = 0; i < 40 && accepted < 5; i++) begin
            if (bus.cmd_ready) accepted++;
            applyRandom(1'b1, 1'b0);
        end
        checkOutput("t2_accepted", accepted, 5);
        repeat (10) applyRandom(1'b1, 1'b0);
        checkOutput("t2_full", bus.cmd_ready, 0);
        checkOutput("t2_hold", bus.rsp_valid, 1);
        drain("t2_drain", 100);

        // Back-to-back stream with tag wrap
        applyReset();
        dlyLo = 0;
        dlyHi = 2;
        sent = 0;
        rspCount = 0;
        for (int i = 0; i < 400 && (sent < 20 || bus.op_valid || bus.rsp_valid || fifoCnt > 0); i++) begin
            if (bus.rsp_valid) begin
                checkOutput("t3_tag_seq", bus.rsp_tag, rspCount % (1 << TAG_W));
                rspCount++;
            end
            cv = (sent < 20);
            if (cv && bus.cmd_ready) sent++;
            applyRandom(cv, 1'b1);
        end
        checkOutput("t3_responses", rspCount, 20);

        // Stray completion while idle
        drain("t4_idle", 50);
        strayNow = 1'b1;
        applyRandom(1'b0, 1'b1);
        applyRandom(1'b0, 1'b1);
        checkOutput("t4_stray", bus.err_stray_done, 1);
        applyRandom(1'b1, 1'b1);
        drain("t4_drain", 50);
        checkOutput("t4_stray_sticky", bus.err_stray_done, 1);

        // Asynchronous reset while BUSY with two commands queued
        stubEnable = 1'b0;
        accepted = 0;
        for (int i = 0; i < 20 && accepted < 3; i++) begin
            if (bus.cmd_ready) accepted++;
            applyRandom(1'b1, 1'b0);
        end
        checkOutput("t5_busy", bus.op_valid, 1);
        applyReset();
        stubEnable = 1'b1;
        applyRandom(1'b1, 1'b0);
        waitRsp("t5_rsp_seen", 20);
        checkOutput("t5_tag", bus.rsp_tag, 0);
        drain("t5_drain", 50);

        // Randomised traffic with occasional stray completions
        dlyLo = 0;
        dlyHi = 4;
        for (int i = 0; i < 800; i++) begin
            if (!bus.op_valid && $urandom_range(40, 0) == 0) strayNow = 1'b1;
            applyRandom(1'($urandom_range(1, 0)), $urandom_range(9, 0) < 6);
        end
        drain("rand_drain", 200);

`ifdef ALU_DISPATCH_TIMEOUT_EN
        // ALU never answers: watchdog must produce the sentinel response
        stubEnable = 1'b0;
        applyRandom(1'b1, 1'b0);
        applyRandom(1'b1, 1'b0);
        waitRsp("t6_rsp_seen", 40);
        checkOutput("t6_result", bus.rsp_result, 32'hDEADBEEF);
        stubEnable = 1'b1;
        drain("t6_drain", 100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
